// File: rtl/ysyx_25040101_imm_pkg.sv
// Shared constants for the immediate generator stage: type encodings and skid-buffer states.
package ysyx_25040101_imm_pkg;

  localparam int unsigned IMM_TYPE_W = 7;

  localparam int unsigned IMM_I_IDX     = 6;
  localparam int unsigned IMM_S_IDX     = 5;
  localparam int unsigned IMM_B_IDX     = 4;
  localparam int unsigned IMM_U_IDX     = 3;
  localparam int unsigned IMM_J_IDX     = 2;
  localparam int unsigned IMM_SHAMT_IDX = 1;
  localparam int unsigned IMM_ZIMM_IDX  = 0;

  localparam logic [IMM_TYPE_W-1:0] IMM_I     = 7'b100_0000;
  localparam logic [IMM_TYPE_W-1:0] IMM_S     = 7'b010_0000;
  localparam logic [IMM_TYPE_W-1:0] IMM_B     = 7'b001_0000;
  localparam logic [IMM_TYPE_W-1:0] IMM_U     = 7'b000_1000;
  localparam logic [IMM_TYPE_W-1:0] IMM_J     = 7'b000_0100;
  localparam logic [IMM_TYPE_W-1:0] IMM_SHAMT = 7'b000_0010;
  localparam logic [IMM_TYPE_W-1:0] IMM_ZIMM  = 7'b000_0001;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  function automatic logic is_onehot(input logic [IMM_TYPE_W-1:0] t);
    return (t != '0) && ((t & (t - IMM_TYPE_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/ysyx_25040101_imm_decode.sv
// Combinational immediate decode from instr[31:7] and a one-hot type.
// err_o exists only with YSYX_25040101_IMM_ERR_EN.
module ysyx_25040101_imm_decode
  import ysyx_25040101_imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [24:0]           raw_i,
  input  logic [IMM_TYPE_W-1:0] type_i,
`ifdef YSYX_25040101_IMM_ERR_EN
  output logic                  err_o,
`endif
  output logic [XLEN-1:0]       imm_o
);

  localparam int unsigned ShamtW = (XLEN == 64) ? 6 : 5;

  // raw_i[k] holds instr[k+7]
  logic sign;
  assign sign = raw_i[24];

  always_comb begin
    imm_o = '0;
    unique case (type_i)
      IMM_I:     imm_o = {{(XLEN-12){sign}}, raw_i[24:13]};
      IMM_S:     imm_o = {{(XLEN-12){sign}}, raw_i[24:18], raw_i[4:0]};
      IMM_B:     imm_o = {{(XLEN-13){sign}}, sign, raw_i[0], raw_i[23:18], raw_i[4:1], 1'b0};
      IMM_U:     imm_o = {{(XLEN-32){sign}}, raw_i[24:5], 12'h000};
      IMM_J:     imm_o = {{(XLEN-21){sign}}, sign, raw_i[12:5], raw_i[13], raw_i[23:14], 1'b0};
      IMM_SHAMT: imm_o = XLEN'(raw_i[13 +: ShamtW]);
      IMM_ZIMM:  imm_o = XLEN'(raw_i[12:8]);
      default:   imm_o = '0;
    endcase
  end

`ifdef YSYX_25040101_IMM_ERR_EN
  assign err_o = !is_onehot(type_i);
`endif

endmodule

// File: rtl/ysyx_25040101_imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer and flush.
// Optional err_o output is enabled by defining YSYX_25040101_IMM_ERR_EN.
module ysyx_25040101_imm_gen_stage
  import ysyx_25040101_imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [24:0]           raw_imm_i,
  input  logic [IMM_TYPE_W-1:0] imm_type_i,
  input  logic [TAG_W-1:0]      tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [XLEN-1:0]       imm_o,
`ifdef YSYX_25040101_IMM_ERR_EN
  output logic                  err_o,
`endif
  output logic [TAG_W-1:0]      tag_o
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
`ifdef YSYX_25040101_IMM_ERR_EN
    logic             err;
`endif
  } entry_t;

  entry_t in_entry;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  state_e state_q, state_d;

  logic push, pop;
  logic head_ld, head_from_skid, skid_ld;

  ysyx_25040101_imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .raw_i  (raw_imm_i),
    .type_i (imm_type_i),
`ifdef YSYX_25040101_IMM_ERR_EN
    .err_o  (in_entry.err),
`endif
    .imm_o  (in_entry.imm)
  );

  assign in_entry.tag = tag_i;

  // Handshake signals come straight from state flops; no out_ready_i -> in_ready_o path.
  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_ld = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_ld = 1'b1;
        end else if (push) begin
          state_d = TWO;
          skid_ld = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d        = ONE;
          head_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush beats any same-cycle transfer on either side.
    if (flush_i) begin
      state_d        = EMPTY;
      head_ld        = 1'b0;
      head_from_skid = 1'b0;
      skid_ld        = 1'b0;
    end
  end

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (head_from_skid) begin
      head_d = skid_q;
    end else if (head_ld) begin
      head_d = in_entry;
    end
    if (skid_ld) begin
      skid_d = in_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign imm_o = head_q.imm;
  assign tag_o = head_q.tag;
`ifdef YSYX_25040101_IMM_ERR_EN
  assign err_o = head_q.err;
`endif

endmodule

// File: tb/tb_ysyx_25040101_imm_gen_stage.sv
// Scoreboard bench: drives XLEN=32 and XLEN=64 instances with identical stimulus.
module tb_ysyx_25040101_imm_gen_stage;
  import ysyx_25040101_imm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [24:0] raw;
  logic [6:0]  typ;
  logic [31:0] tag;
  logic        rdy32, rdy64, ov32, ov64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic        err32, err64;

  ysyx_25040101_imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .raw_imm_i(raw), .imm_type_i(typ), .tag_i(tag), .out_valid_o(ov32), .out_ready_i(out_ready),
    .imm_o(imm32),
`ifdef YSYX_25040101_IMM_ERR_EN
    .err_o(err32),
`endif
    .tag_o(tag32)
  );

  ysyx_25040101_imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy64),
    .raw_imm_i(raw), .imm_type_i(typ), .tag_i(tag), .out_valid_o(ov64), .out_ready_i(out_ready),
    .imm_o(imm64),
`ifdef YSYX_25040101_IMM_ERR_EN
    .err_o(err64),
`endif
    .tag_o(tag64)
  );

`ifndef YSYX_25040101_IMM_ERR_EN
  assign err32 = 1'b0;
  assign err64 = 1'b0;
`endif

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        err;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Reference: rebuild the instruction word and read fields as the ISA defines them.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [6:0] t,
                                          input int xlen);
    logic signed [11:0] i12, s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    logic signed [63:0] v;
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    u32 = {ins[31:12], 12'h000};
    v = '0;
    if ($countones(t) == 1) begin
      if (t[6])      v = 64'(i12);
      else if (t[5]) v = 64'(s12);
      else if (t[4]) v = 64'(b13);
      else if (t[3]) v = 64'(u32);
      else if (t[2]) v = 64'(j21);
      else if (t[1]) v = (xlen == 64) ? {58'b0, ins[25:20]} : {59'b0, ins[24:20]};
      else           v = {59'b0, ins[19:15]};
    end
    if (xlen == 32) v[63:32] = '0;
    return v;
  endfunction

  function automatic exp_t mk(input int xlen);
    exp_t e;
    e.imm = ref_imm({raw, 7'b0}, typ, xlen);
    e.tag = tag;
`ifdef YSYX_25040101_IMM_ERR_EN
    e.err = ($countones(typ) != 1);
`else
    e.err = 1'b0;
`endif
    return e;
  endfunction

  // Stimulus side: record expected responses on each accepted beat.
  always @(negedge clk) begin
    if (rst_n && !flush && in_valid) begin
      if (rdy32) q32.push_back(mk(32));
      if (rdy64) q64.push_back(mk(64));
    end
  end

  // Monitor side: pop and compare on each output beat.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n || flush) begin
      q32.delete();
      q64.delete();
    end else begin
      if (ov32 && out_ready) begin
        if (q32.size() == 0) check("out32 unexpected", {32'b0, imm32, tag32}, '0);
        else begin
          e = q32.pop_front();
          check("out32", {63'b0, err32, 32'b0, imm32, tag32}, {63'b0, e.err, e.imm, e.tag});
        end
      end
      if (ov64 && out_ready) begin
        if (q64.size() == 0) check("out64 unexpected", {imm64, tag64}, '0);
        else begin
          e = q64.pop_front();
          check("out64", {63'b0, err64, imm64, tag64}, {63'b0, e.err, e.imm, e.tag});
        end
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [6:0] t, input logic [31:0] tg);
    in_valid = 1'b1;
    raw      = ins[31:7];
    typ      = t;
    tag      = tg;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (rdy32) break;
      n++;
      if (n >= 50) begin
        check("accept timeout", 128'd0, 128'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] ins, input logic [6:0] t, input logic [31:0] tg);
    drive(ins, t, tg);
    wait_accept();
  endtask

  // Direct check of the head one cycle after acceptance (out_ready assumed 1).
  task automatic send_chk(input string name, input logic [31:0] ins, input logic [6:0] t,
                          input logic [31:0] tg, input logic [31:0] e32, input logic [63:0] e64,
                          input logic eerr);
    send(ins, t, tg);
    @(negedge clk);
    check({name, "_32"}, {63'b0, ov32, 32'b0, imm32, tag32}, {63'b0, 1'b1, 32'b0, e32, tg});
    check({name, "_64"}, {63'b0, ov64, imm64, tag64}, {63'b0, 1'b1, e64, tg});
`ifdef YSYX_25040101_IMM_ERR_EN
    check({name, "_err"}, {126'b0, err32, err64}, {126'b0, eerr, eerr});
`else
    if (eerr) check({name, "_noerr"}, {127'b0, err32}, 128'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!ov32 && !ov64) break;
      n++;
      if (n >= 20) begin
        check("drain timeout", 128'd0, 128'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string name);
    check({name, "_32"}, {63'b0, ov32, rdy32, err32, imm32, tag32}, {64'b0, 1'b1, 65'b0});
    check({name, "_64"}, {29'b0, ov64, rdy64, err64, imm64, tag64}, {30'b0, 1'b1, 97'b0});
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    raw = '0; typ = '0; tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n     = 1'b1;
    out_ready = 1'b1;

    send_chk("addi", 32'hFFF00093, IMM_I, 32'h100, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_chk("beq", 32'hFE000EE3, IMM_B, 32'h104, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send_chk("jal", 32'h0080006F, IMM_J, 32'h108, 32'h8, 64'h8, 1'b0);
    send_chk("lui", 32'h80000037, IMM_U, 32'h10C, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send_chk("slli", 32'h03F09093, IMM_SHAMT, 32'h110, 32'h1F, 64'h3F, 1'b0);
    send_chk("zimm", 32'h340FD073, IMM_ZIMM, 32'h114, 32'h1F, 64'h1F, 1'b0);
    send_chk("sw", 32'hFE112E23, IMM_S, 32'h118, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send_chk("multi", 32'hFFF00093, 7'b0000011, 32'h11C, 32'h0, 64'h0, 1'b1);
    send_chk("none", 32'hFFF00093, 7'b0000000, 32'h120, 32'h0, 64'h0, 1'b1);
    drain();

    // Backpressure: two entries fill the buffer, third must stall.
    out_ready = 1'b0;
    send(32'h00100093, IMM_I, 32'd1);
    send(32'h00200093, IMM_I, 32'd2);
    drive(32'h00300093, IMM_I, 32'd3);
    @(negedge clk);
    check("full_ready", {126'b0, rdy32, rdy64}, 128'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Flush while full with a pending request: nothing survives.
    out_ready = 1'b0;
    send(32'h00400093, IMM_I, 32'd4);
    send(32'h00500093, IMM_I, 32'd5);
    drive(32'h00600093, IMM_I, 32'd6);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_state", {124'b0, ov32, ov64, rdy32, rdy64}, {124'b0, 4'b0011});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset between edges with entries held.
    out_ready = 1'b0;
    send(32'h00700093, IMM_I, 32'd7);
    send(32'h00800093, IMM_I, 32'd8);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_chk("post_rst", 32'h12345093, 7'b0000011, 32'h200, 32'h0, 64'h0, 1'b1);

    // Randomized traffic with backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      raw       = 25'($urandom);
      tag       = $urandom;
      if ($urandom_range(0, 9) < 8) typ = 7'(1 << $urandom_range(0, 6));
      else typ = 7'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    drain();
    check("queues_empty", 128'(q32.size() + q64.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
